// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a per-register pending-write scoreboard.
// Optional CSR decode is enabled by defining DECODE_STAGE_CSR_EN.
module decode_stage #(
  parameter int XLEN        = 32,
  parameter int MAX_PENDING = 3
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [4:0]      out_rd_o,
  output logic            out_regfile_we_o,
  output logic            out_csr_we_o,
  output logic            out_mem_rd_o,
  output logic            out_mem_wr_o,
  output logic            out_branch_o,
  output logic            out_jump_o,
  output logic            out_illegal_o,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  input  logic            flush_i
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = in_instr_i[6:0];
  assign funct3 = in_instr_i[14:12];
  assign rd     = in_instr_i[11:7];
  assign rs1    = in_instr_i[19:15];
  assign rs2    = in_instr_i[24:20];

  logic dec_we, dec_mrd, dec_mwr, dec_br, dec_jmp, dec_ill;
  logic rs1_used, rs2_used;
`ifdef DECODE_STAGE_CSR_EN
  logic dec_csr;
`endif

  always_comb begin
    dec_we   = 1'b0;
    dec_mrd  = 1'b0;
    dec_mwr  = 1'b0;
    dec_br   = 1'b0;
    dec_jmp  = 1'b0;
    dec_ill  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
`ifdef DECODE_STAGE_CSR_EN
    dec_csr  = 1'b0;
`endif
    if (in_instr_i[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI, OPC_AUIPC: dec_we = 1'b1;
        OPC_JAL:    begin dec_we = 1'b1; dec_jmp = 1'b1; end
        OPC_JALR:   begin dec_we = 1'b1; dec_jmp = 1'b1; rs1_used = 1'b1; end
        OPC_BRANCH: begin dec_br = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
        OPC_LOAD:   begin dec_we = 1'b1; dec_mrd = 1'b1; rs1_used = 1'b1; end
        OPC_STORE:  begin dec_mwr = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
        OPC_OP_IMM: begin dec_we = 1'b1; rs1_used = 1'b1; end
        OPC_OP:     begin dec_we = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
        OPC_MISC_MEM: ;
        OPC_SYSTEM: begin
          // funct3 000 (ECALL/EBREAK/xRET) is legal with no side effects
          if (funct3 == 3'b100) begin
            dec_ill = 1'b1;
          end else if (funct3 != 3'b000) begin
`ifdef DECODE_STAGE_CSR_EN
            dec_we   = 1'b1;
            dec_csr  = 1'b1;
            rs1_used = !funct3[2];
`else
            dec_ill  = 1'b1;
`endif
          end
        end
        default: dec_ill = 1'b1;
      endcase
    end
  end

  // Scoreboard: x0 entry is held at zero so lookups need no special case.
  logic [CW-1:0] pending     [32];
  logic [CW-1:0] pending_nxt [32];
  logic          hazard, accept;
  logic [31:0]   inc_vec, wb_vec, fl_vec;

  assign hazard = (rs1_used && rs1 != 5'd0 && pending[rs1] != '0)
               || (rs2_used && rs2 != 5'd0 && pending[rs2] != '0)
               || (dec_we && rd != 5'd0 && pending[rd] == CW'(MAX_PENDING));

  // Handshake: a transfer happens on a clock edge where valid and ready are
  // both high; ready never depends on valid, and valid/data are held until taken.
  assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  assign inc_vec = (accept && dec_we) ? (32'd1 << rd) : 32'd0;
  assign wb_vec  = wb_valid_i ? (32'd1 << wb_rd_i) : 32'd0;
  assign fl_vec  = (flush_i && out_valid_o && out_regfile_we_o) ? (32'd1 << out_rd_o) : 32'd0;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      pending_nxt[r] = pending[r];
      if (inc_vec[r]) begin
        if (!wb_vec[r]) pending_nxt[r] = pending[r] + CW'(1);
      end else if (wb_vec[r] && fl_vec[r]) begin
        pending_nxt[r] = (pending[r] > CW'(1)) ? pending[r] - CW'(2) : '0;
      end else if (wb_vec[r] || fl_vec[r]) begin
        pending_nxt[r] = (pending[r] != '0) ? pending[r] - CW'(1) : '0;
      end
    end
    pending_nxt[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < 32; r++) pending[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) pending[r] <= pending_nxt[r];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_o      <= 1'b0;
      out_instr_o      <= '0;
      out_pc_o         <= '0;
      out_rd_o         <= '0;
      out_regfile_we_o <= 1'b0;
      out_mem_rd_o     <= 1'b0;
      out_mem_wr_o     <= 1'b0;
      out_branch_o     <= 1'b0;
      out_jump_o       <= 1'b0;
      out_illegal_o    <= 1'b0;
    end else if (accept) begin
      out_valid_o      <= 1'b1;
      out_instr_o      <= in_instr_i;
      out_pc_o         <= in_pc_i;
      out_rd_o         <= rd;
      out_regfile_we_o <= dec_we;
      out_mem_rd_o     <= dec_mrd;
      out_mem_wr_o     <= dec_mwr;
      out_branch_o     <= dec_br;
      out_jump_o       <= dec_jmp;
      out_illegal_o    <= dec_ill;
    end else if (out_ready_i || flush_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef DECODE_STAGE_CSR_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)     out_csr_we_o <= 1'b0;
    else if (accept) out_csr_we_o <= dec_csr;
  end
`else
  assign out_csr_we_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: scoreboarded output checks plus hazard/flush scenarios.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int MAXP = 3;
  localparam int W    = 32 + XLEN + 5 + 7;
`ifdef DECODE_STAGE_CSR_EN
  localparam logic CSR_ON = 1'b1;
`else
  localparam logic CSR_ON = 1'b0;
`endif

  logic            clk, reset_i;
  logic            in_valid_i, in_ready_o;
  logic [31:0]     in_instr_i;
  logic [XLEN-1:0] in_pc_i;
  logic            out_valid_o, out_ready_i;
  logic [31:0]     out_instr_o;
  logic [XLEN-1:0] out_pc_o;
  logic [4:0]      out_rd_o;
  logic            out_regfile_we_o, out_csr_we_o, out_mem_rd_o, out_mem_wr_o;
  logic            out_branch_o, out_jump_o, out_illegal_o;
  logic            wb_valid_i, flush_i;
  logic [4:0]      wb_rd_i;

  decode_stage #(.XLEN(XLEN), .MAX_PENDING(MAXP)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .out_rd_o(out_rd_o),
    .out_regfile_we_o(out_regfile_we_o), .out_csr_we_o(out_csr_we_o),
    .out_mem_rd_o(out_mem_rd_o), .out_mem_wr_o(out_mem_wr_o),
    .out_branch_o(out_branch_o), .out_jump_o(out_jump_o),
    .out_illegal_o(out_illegal_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int   pend[32];
  logic m_valid;
  logic [W-1:0] obs;

  assign obs = {out_instr_o, out_pc_o, out_rd_o, out_regfile_we_o, out_csr_we_o,
                out_mem_rd_o, out_mem_wr_o, out_branch_o, out_jump_o, out_illegal_o};

  typedef struct packed {
    logic we, csr, mrd, mwr, br, jmp, ill, u1, u2;
  } dec_t;

  function automatic dec_t model(input logic [31:0] i);
    dec_t d;
    logic [2:0] f3;
    d  = '0;
    f3 = i[14:12];
    if (i[1:0] != 2'b11) begin
      d.ill = 1'b1;
      return d;
    end
    case (i[6:2])
      5'b01101, 5'b00101: d.we = 1'b1;
      5'b11011: begin d.we = 1'b1; d.jmp = 1'b1; end
      5'b11001: begin d.we = 1'b1; d.jmp = 1'b1; d.u1 = 1'b1; end
      5'b11000: begin d.br = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
      5'b00000: begin d.we = 1'b1; d.mrd = 1'b1; d.u1 = 1'b1; end
      5'b01000: begin d.mwr = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
      5'b00100: begin d.we = 1'b1; d.u1 = 1'b1; end
      5'b01100: begin d.we = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
      5'b00011: ;
      5'b11100: begin
        if (f3 == 3'b100) d.ill = 1'b1;
        else if (f3 != 3'b000) begin
          if (CSR_ON) begin
            d.we = 1'b1; d.csr = 1'b1;
            d.u1 = (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011);
          end else begin
            d.ill = 1'b1;
          end
        end
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [W-1:0] exp_fields(input logic [31:0] i, input logic [XLEN-1:0] pc);
    dec_t d;
    d = model(i);
    return {i, pc, i[11:7], d.we, d.csr, d.mrd, d.mwr, d.br, d.jmp, d.ill};
  endfunction

  // driver tasks
  task automatic idle();
    in_valid_i = 1'b0;
    wb_valid_i = 1'b0;
    wb_rd_i    = 5'd0;
    flush_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    m_valid = 1'b0;
    exp_q.delete();
    for (int r = 0; r < 32; r++) pend[r] = 0;
  endtask

  // One clock cycle: predict ready, score the output transfer, update the model.
  task automatic tick();
    dec_t d;
    logic hz, exp_rdy, acc, f_we;
    logic [4:0] rs1, rs2, rd, f_rd;
    logic [W-1:0] front;
    #1;
    d   = model(in_instr_i);
    rd  = in_instr_i[11:7];
    rs1 = in_instr_i[19:15];
    rs2 = in_instr_i[24:20];
    hz  = (d.u1 && rs1 != 0 && pend[rs1] != 0) || (d.u2 && rs2 != 0 && pend[rs2] != 0)
       || (d.we && rd != 0 && pend[rd] == MAXP);
    exp_rdy = (!m_valid || out_ready_i) && !hz && !flush_i;
    checks++;
    if (in_ready_o !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b exp %b at %0t", in_ready_o, exp_rdy, $time);
    end
    acc  = in_valid_i && exp_rdy;
    f_we = 1'b0;
    f_rd = 5'd0;
    if (m_valid && exp_q.size() > 0) begin
      f_we = exp_q[0][6];
      f_rd = exp_q[0][11:7];
    end
    if (m_valid && (out_ready_i || flush_i)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got valid output exp none at %0t", $time);
      end else begin
        front = exp_q.pop_front();
        if (!flush_i && obs !== front) begin
          errors++;
          $display("FAIL out_fields: got %h exp %h at %0t", obs, front, $time);
        end
      end
    end
    if (acc && d.we && rd != 0) pend[rd]++;
    if (wb_valid_i && wb_rd_i != 0 && pend[wb_rd_i] > 0) pend[wb_rd_i]--;
    if (flush_i && m_valid && f_we && f_rd != 0 && pend[f_rd] > 0) pend[f_rd]--;
    if (acc) begin
      exp_q.push_back(exp_fields(in_instr_i, in_pc_i));
      m_valid = 1'b1;
    end else if (out_ready_i || flush_i) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid_o !== m_valid) begin
      errors++;
      $display("FAIL out_valid: got %b exp %b at %0t", out_valid_o, m_valid, $time);
    end
  endtask

  task automatic test_reset();
    in_instr_i = 32'h0; in_pc_i = '0; out_ready_i = 1'b1;
    do_reset();
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid_o); end
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_fields: got %h exp 0", obs); end
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", in_ready_o); end
    tick();
  endtask

  task automatic test_raw_hazard();
    do_reset();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_instr_i = 32'h00500093; in_pc_i = 32'h100;
    tick();
    in_instr_i = 32'h00108133; in_pc_i = 32'h104;
    checks++;
    if ({out_valid_o, out_regfile_we_o, out_rd_o} !== {1'b1, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL addi_out: got %b/%b/%0d exp 1/1/1", out_valid_o, out_regfile_we_o, out_rd_o);
    end
    repeat (2) begin
      #1; checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b exp 0", in_ready_o); end
      tick();
    end
    wb_valid_i = 1'b1; wb_rd_i = 5'd1;
    #1; checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got %b exp 0", in_ready_o); end
    tick();
    wb_valid_i = 1'b0;
    #1; checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL raw_release: got %b exp 1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_instr_i = 32'h00100193; in_pc_i = 32'h200;
    held = exp_fields(32'h00100193, 32'h200);
    tick();
    in_instr_i = 32'h00200213; in_pc_i = 32'h204;
    repeat (3) begin
      #1; checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b exp 0", in_ready_o); end
      checks++;
      if (obs !== held) begin errors++; $display("FAIL bp_stable: got %h exp %h", obs, held); end
      tick();
    end
    out_ready_i = 1'b1;
    #1; checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b exp 1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_instr_i = 32'h00100293; in_pc_i = 32'h280;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL sat_accept%0d: got %b exp 1", i, in_ready_o); end
      tick();
    end
    #1; checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL sat_stall: got %b exp 0", in_ready_o); end
    tick();
    wb_valid_i = 1'b1; wb_rd_i = 5'd5;
    tick();
    wb_valid_i = 1'b0;
    #1; checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL sat_release: got %b exp 1", in_ready_o); end
    tick();
    in_valid_i = 1'b0; wb_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b1;
    tick();
    wb_valid_i = 1'b0;
    #1; checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL sat_incdec: got %b exp 1", in_ready_o); end
    tick();
    #1; checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL sat_full: got %b exp 0", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_instr_i = 32'h00002383; in_pc_i = 32'h300;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (out_mem_rd_o !== 1'b1) begin errors++; $display("FAIL lw_mem_rd: got %b exp 1", out_mem_rd_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b exp 0", out_valid_o); end
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_instr_i = 32'h00038433; in_pc_i = 32'h304;
    #1; checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_dec: got %b exp 1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    tick();
    in_valid_i = 1'b1; in_instr_i = 32'h00002383; in_pc_i = 32'h310;
    tick(); tick();
    in_valid_i = 1'b0; flush_i = 1'b1; wb_valid_i = 1'b1; wb_rd_i = 5'd7;
    tick();
    idle();
    in_valid_i = 1'b1; in_instr_i = 32'h00038433; in_pc_i = 32'h314;
    #1; checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_wb_double: got %b exp 1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_csr_illegal();
    do_reset();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_instr_i = 32'h300211F3; in_pc_i = 32'h400;
    tick();
    in_instr_i = 32'h00000000; in_pc_i = 32'h404;
    checks++;
    if ({out_regfile_we_o, out_csr_we_o, out_illegal_o} !== {CSR_ON, CSR_ON, !CSR_ON}) begin
      errors++;
      $display("FAIL csrrw_flags: got %b%b%b exp %b%b%b", out_regfile_we_o, out_csr_we_o,
               out_illegal_o, CSR_ON, CSR_ON, !CSR_ON);
    end
    tick();
    in_instr_i = 32'h00500090; in_pc_i = 32'h408;
    checks++;
    if ({out_illegal_o, out_regfile_we_o} !== 2'b10) begin
      errors++;
      $display("FAIL zero_illegal: got %b%b exp 10", out_illegal_o, out_regfile_we_o);
    end
    tick();
    in_instr_i = 32'h00018433; in_pc_i = 32'h40c;
    checks++;
    if (out_illegal_o !== 1'b1) begin errors++; $display("FAIL lowbits_illegal: got %b exp 1", out_illegal_o); end
    #1; checks++;
    if (in_ready_o !== !CSR_ON) begin errors++; $display("FAIL csr_hazard: got %b exp %b", in_ready_o, !CSR_ON); end
    tick();
    in_valid_i = 1'b0; wb_valid_i = 1'b1; wb_rd_i = 5'd3;
    tick();
    wb_valid_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_underflow();
    do_reset();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_instr_i = 32'h00100493; in_pc_i = 32'h500;
    repeat (3) tick();
    do_reset();
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b exp 0", out_valid_o); end
    wb_valid_i = 1'b1; wb_rd_i = 5'd9;
    tick(); tick();
    wb_valid_i = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL underflow%0d: got %b exp 1", i, in_ready_o); end
      tick();
    end
    #1; checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL underflow_full: got %b exp 0", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] opc_tab [13];
    logic [31:0] ins;
    opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b1110011,
                7'b0101010};
    do_reset();
    for (int n = 0; n < 300; n++) begin
      ins        = $urandom();
      ins[6:0]   = opc_tab[$urandom_range(0, 12)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      in_instr_i  = ins;
      in_pc_i     = XLEN'(n * 4);
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      wb_valid_i  = ($urandom_range(0, 2) == 0);
      wb_rd_i     = 5'($urandom_range(0, 7));
      flush_i     = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle();
    out_ready_i = 1'b1;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain: got %0d queued valid=%b exp 0 queued valid=0", exp_q.size(), out_valid_o);
    end
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    out_ready_i = 1'b1;
    in_instr_i = 32'h0;
    in_pc_i = '0;
    m_valid = 1'b0;
    test_reset();
    test_raw_hazard();
    test_backpressure();
    test_saturate();
    test_flush();
    test_csr_illegal();
    test_underflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
